// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline stall/flush sequencer.
package pipeline_ctrl_pkg;

    localparam int unsigned REG_ADDR_W_DEF = 5;
    localparam int unsigned ZERO_REG       = 0;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard inputs from the pipeline and hold/kill strobes back to its registers.
interface pipeline_hazard_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
    parameter int unsigned CNT_W      = 32
);
    logic [REG_ADDR_W-1:0] rs1_id;
    logic [REG_ADDR_W-1:0] rs2_id;
    logic [REG_ADDR_W-1:0] rd_ex;
    logic                  use_rs1_id;
    logic                  use_rs2_id;
    logic                  load_ex;
    logic                  mem_req;
    logic                  mem_ready;
    logic                  redirect_mem;
    logic                  halt_id;
    logic                  halt_wb;

    logic                  pc_hold;
    logic                  wen_if_id;
    logic                  wen_id_ex;
    logic                  wen_ex_mem;
    logic                  wen_mem_wb;
    logic                  kill_if_id;
    logic                  kill_id_ex;
    logic                  kill_ex_mem;
    logic                  kill_mem_wb;
    logic                  halted;
    logic                  mem_err;
    logic [CNT_W-1:0]      stall_cycles;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output rs1_id, rs2_id, rd_ex, use_rs1_id, use_rs2_id, load_ex,
               mem_req, mem_ready, redirect_mem, halt_id, halt_wb,
        input  pc_hold, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb,
               kill_if_id, kill_id_ex, kill_ex_mem, kill_mem_wb,
               halted, mem_err, stall_cycles, flush_count
    );

    modport slave (
        input  rs1_id, rs2_id, rd_ex, use_rs1_id, use_rs2_id, load_ex,
               mem_req, mem_ready, redirect_mem, halt_id, halt_wb,
        output pc_hold, wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb,
               kill_if_id, kill_id_ex, kill_ex_mem, kill_mem_wb,
               halted, mem_err, stall_cycles, flush_count
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_load_use.sv
// Load-use hazard compare: ID reads a register the EX-stage load is about to write.
module load_use_detect
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF
) (
    input  logic [REG_ADDR_W-1:0] rs1_id,
    input  logic [REG_ADDR_W-1:0] rs2_id,
    input  logic [REG_ADDR_W-1:0] rd_ex,
    input  logic                  use_rs1_id,
    input  logic                  use_rs2_id,
    input  logic                  load_ex,
    output logic                  stall_c
);

    // x0 is hardwired zero, so a load targeting it never creates a dependency
    assign stall_c = load_ex && (rd_ex != REG_ADDR_W'(ZERO_REG)) &&
                     ((use_rs1_id && (rs1_id == rd_ex)) ||
                      (use_rs2_id && (rs2_id == rd_ex)));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stall/flush sequencer: load-use, memory wait with timeout, redirect, halt drain.
// Define PIPE_PERF_CNT_EN to build the saturating stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned REG_ADDR_W  = REG_ADDR_W_DEF,
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 32
) (
    input logic                  CLK,
    input logic                  RST,
    pipeline_hazard_ctrl_if.slave bus
);

    localparam int unsigned TMO_W = $clog2(MEM_TIMEOUT + 1);

    ctrl_state_e      state_q, state_d, ret_q, ret_d, eval_st;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic             mem_err_q, mem_err_d;
    logic             lu_stall_c, mem_wait_c;
    logic             pc_hold_c;
    logic             wen_if_id_c, wen_id_ex_c, wen_ex_mem_c, wen_mem_wb_c;
    logic             kill_if_id_c, kill_id_ex_c, kill_ex_mem_c, kill_mem_wb_c;

    load_use_detect #(.REG_ADDR_W(REG_ADDR_W)) u_load_use (
        .rs1_id     (bus.rs1_id),
        .rs2_id     (bus.rs2_id),
        .rd_ex      (bus.rd_ex),
        .use_rs1_id (bus.use_rs1_id),
        .use_rs2_id (bus.use_rs2_id),
        .load_ex    (bus.load_ex),
        .stall_c    (lu_stall_c)
    );

    assign mem_wait_c = bus.mem_req & ~bus.mem_ready;

    always_comb begin
        state_d       = state_q;
        ret_d         = ret_q;
        tmo_d         = tmo_q;
        mem_err_d     = mem_err_q;
        pc_hold_c     = 1'b0;
        wen_if_id_c   = 1'b0;
        wen_id_ex_c   = 1'b0;
        wen_ex_mem_c  = 1'b0;
        wen_mem_wb_c  = 1'b0;
        kill_if_id_c  = 1'b0;
        kill_id_ex_c  = 1'b0;
        kill_ex_mem_c = 1'b0;
        kill_mem_wb_c = 1'b0;

        // The cycle the memory completes is handled as the state the wait interrupted
        eval_st = (state_q == ST_MEM_WAIT && bus.mem_ready) ? ret_q : state_q;
        tmo_inc = (eval_st == ST_MEM_WAIT) ? tmo_q + TMO_W'(1) : TMO_W'(1);

        if (eval_st == ST_HALTED) begin
            pc_hold_c    = 1'b1;
            wen_if_id_c  = 1'b1;
            wen_id_ex_c  = 1'b1;
            wen_ex_mem_c = 1'b1;
            wen_mem_wb_c = 1'b1;
        end else if (eval_st == ST_MEM_WAIT || mem_wait_c) begin
            pc_hold_c     = 1'b1;
            wen_if_id_c   = 1'b1;
            wen_id_ex_c   = 1'b1;
            wen_ex_mem_c  = 1'b1;
            kill_mem_wb_c = 1'b1;
            tmo_d         = tmo_inc;
            if (eval_st != ST_MEM_WAIT) ret_d = eval_st;
            if (tmo_inc == TMO_W'(MEM_TIMEOUT)) begin
                mem_err_d = 1'b1;
                tmo_d     = '0;
                state_d   = ST_HALTED;
            end else begin
                state_d   = ST_MEM_WAIT;
            end
        end else begin
            tmo_d   = '0;
            state_d = eval_st;
            if (eval_st == ST_DRAIN) begin
                pc_hold_c    = 1'b1;
                kill_if_id_c = 1'b1;
            end
            // A redirect squashes any pending halt: it was fetched down the wrong path
            if (bus.redirect_mem) begin
                pc_hold_c     = 1'b0;
                kill_if_id_c  = 1'b1;
                kill_id_ex_c  = 1'b1;
                kill_ex_mem_c = 1'b1;
                state_d       = ST_RUN;
            end else if (lu_stall_c) begin
                pc_hold_c    = 1'b1;
                wen_if_id_c  = 1'b1;
                kill_if_id_c = 1'b0;
                kill_id_ex_c = 1'b1;
            end else if (eval_st == ST_RUN && bus.halt_id) begin
                state_d = ST_DRAIN;
            end else if (eval_st == ST_DRAIN && bus.halt_wb) begin
                state_d = ST_HALTED;
            end
        end
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            tmo_q     <= '0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            tmo_q     <= tmo_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign bus.pc_hold     = pc_hold_c     & ~RST;
    assign bus.wen_if_id   = wen_if_id_c   & ~RST;
    assign bus.wen_id_ex   = wen_id_ex_c   & ~RST;
    assign bus.wen_ex_mem  = wen_ex_mem_c  & ~RST;
    assign bus.wen_mem_wb  = wen_mem_wb_c  & ~RST;
    assign bus.kill_if_id  = kill_if_id_c  & ~RST;
    assign bus.kill_id_ex  = kill_id_ex_c  & ~RST;
    assign bus.kill_ex_mem = kill_ex_mem_c & ~RST;
    assign bus.kill_mem_wb = kill_mem_wb_c & ~RST;
    assign bus.halted      = (state_q == ST_HALTED);
    assign bus.mem_err     = mem_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    // kill_ex_mem is raised only by an accepted redirect, so it marks each flush
    always_comb begin
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;
        if (pc_hold_c && state_q != ST_HALTED && stall_cycles_q != '1)
            stall_cycles_d = stall_cycles_q + CNT_W'(1);
        if (kill_ex_mem_c && flush_count_q != '1)
            flush_count_d = flush_count_q + CNT_W'(1);
    end

    always_ff @(negedge CLK or posedge RST) begin
        if (RST) begin
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign bus.stall_cycles = stall_cycles_q;
    assign bus.flush_count  = flush_count_q;
`else
    assign bus.stall_cycles = CNT_W'(0);
    assign bus.flush_count  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: per-cycle expected strobes via a scoreboard queue.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [7:0] fl;
    } stim_t;

    localparam logic [7:0] F_U1   = 8'h80;
    localparam logic [7:0] F_U2   = 8'h40;
    localparam logic [7:0] F_LD   = 8'h20;
    localparam logic [7:0] F_MREQ = 8'h10;
    localparam logic [7:0] F_MRDY = 8'h08;
    localparam logic [7:0] F_RED  = 8'h04;
    localparam logic [7:0] F_HID  = 8'h02;
    localparam logic [7:0] F_HWB  = 8'h01;

    // {pc_hold, wen if/id id/ex ex/mem mem/wb, kill if/id id/ex ex/mem mem/wb, halted, mem_err}
    localparam logic [10:0] E_0    = 11'b0_0000_0000_0_0;
    localparam logic [10:0] E_LU   = 11'b1_1000_0100_0_0;
    localparam logic [10:0] E_MW   = 11'b1_1110_0001_0_0;
    localparam logic [10:0] E_RD   = 11'b0_0000_1110_0_0;
    localparam logic [10:0] E_DR   = 11'b1_0000_1000_0_0;
    localparam logic [10:0] E_HALT = 11'b1_1111_0000_1_0;
    localparam logic [10:0] E_TMO  = 11'b1_1111_0000_1_1;

    logic CLK;
    logic RST;
    int   total;
    int   bad;
    logic [10:0] exp_q [$];

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(5), .CNT_W(32)) bus ();

    pipeline_hazard_ctrl #(.REG_ADDR_W(5), .MEM_TIMEOUT(4), .CNT_W(32)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic stim_t mk(input int unsigned rs1, input int unsigned rs2,
                                 input int unsigned rd, input logic [7:0] fl);
        stim_t r;
        r.rs1 = 5'(rs1);
        r.rs2 = 5'(rs2);
        r.rd  = 5'(rd);
        r.fl  = fl;
        return r;
    endfunction

    function automatic logic [10:0] obs();
        return {bus.pc_hold, bus.wen_if_id, bus.wen_id_ex, bus.wen_ex_mem, bus.wen_mem_wb,
                bus.kill_if_id, bus.kill_id_ex, bus.kill_ex_mem, bus.kill_mem_wb,
                bus.halted, bus.mem_err};
    endfunction

    task automatic apply(input stim_t s);
        bus.rs1_id       = s.rs1;
        bus.rs2_id       = s.rs2;
        bus.rd_ex        = s.rd;
        bus.use_rs1_id   = s.fl[7];
        bus.use_rs2_id   = s.fl[6];
        bus.load_ex      = s.fl[5];
        bus.mem_req      = s.fl[4];
        bus.mem_ready    = s.fl[3];
        bus.redirect_mem = s.fl[2];
        bus.halt_id      = s.fl[1];
        bus.halt_wb      = s.fl[0];
    endtask

    // Inputs change after the rising edge; the DUT state moves on the falling edge
    task automatic drive_cycle(input stim_t s, input logic [10:0] e);
        @(posedge CLK);
        apply(s);
        exp_q.push_back(e);
    endtask

    task automatic do_reset();
        @(posedge CLK);
        RST = 1'b1;
        apply(mk(0, 0, 0, 8'h00));
        @(posedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge CLK);
        RST = 1'b1;
        apply(mk(5, 5, 5, F_U1 | F_LD | F_MREQ | F_RED | F_HID));
        #1;
        total++;
        if (obs() !== E_0) begin
            bad++;
            $display("FAIL reset_outputs got=%b want=%b", obs(), E_0);
        end
        @(negedge CLK);
        #1;
        total++;
        if (obs() !== E_0) begin
            bad++;
            $display("FAIL reset_after_edge got=%b want=%b", obs(), E_0);
        end
        total++;
        if (bus.stall_cycles !== 32'd0 || bus.flush_count !== 32'd0) begin
            bad++;
            $display("FAIL reset_counters got=%0d/%0d want=0/0", bus.stall_cycles, bus.flush_count);
        end
        @(posedge CLK);
        RST = 1'b0;
        apply(mk(0, 0, 0, 8'h00));
    endtask

    task automatic test_load_use();
        stim_t s [0:7];
        logic [10:0] e [0:7];
        logic [10:0] want;
        s = '{mk(0, 0, 0, 8'h00),
              mk(5, 3, 5, F_LD | F_U1 | F_U2),
              mk(5, 3, 0, F_U1 | F_U2),
              mk(0, 0, 0, F_LD | F_U1 | F_U2),
              mk(2, 7, 7, F_LD | F_U2),
              mk(2, 7, 7, F_LD | F_U1),
              mk(9, 9, 9, F_U1 | F_U2),
              mk(31, 4, 31, F_LD | F_U1)};
        e = '{E_0, E_LU, E_0, E_0, E_LU, E_0, E_0, E_LU};
        foreach (s[i]) begin
            drive_cycle(s[i], e[i]);
            #1;
            want = exp_q.pop_front();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL load_use[%0d] got=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_mem_wait();
        stim_t s [0:5];
        logic [10:0] e [0:5];
        logic [10:0] want;
        s = '{mk(0, 0, 0, F_MREQ),
              mk(5, 0, 5, F_MREQ | F_RED | F_LD | F_U1),
              mk(0, 0, 0, F_MREQ | F_HID),
              mk(0, 0, 0, F_MREQ | F_MRDY),
              mk(6, 0, 6, F_LD | F_U1),
              mk(0, 0, 0, 8'h00)};
        e = '{E_MW, E_MW, E_MW, E_0, E_LU, E_0};
        foreach (s[i]) begin
            drive_cycle(s[i], e[i]);
            #1;
            want = exp_q.pop_front();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL mem_wait[%0d] got=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_redirect();
        stim_t s [0:8];
        logic [10:0] e [0:8];
        logic [10:0] want;
        s = '{mk(0, 0, 0, F_HID),
              mk(0, 0, 0, F_RED),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, F_HWB),
              mk(5, 0, 5, F_RED | F_HID | F_LD | F_U1),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, F_MREQ | F_RED),
              mk(0, 0, 0, F_MREQ | F_MRDY),
              mk(0, 0, 0, 8'h00)};
        e = '{E_0, E_RD, E_0, E_0, E_RD, E_0, E_MW, E_0, E_0};
        foreach (s[i]) begin
            drive_cycle(s[i], e[i]);
            #1;
            want = exp_q.pop_front();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL redirect[%0d] got=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_drain_halt();
        stim_t s [0:13];
        logic [10:0] e [0:13];
        logic [10:0] want;
        s = '{mk(0, 0, 0, F_HID),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, F_HWB),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, F_RED | F_MREQ),
              mk(0, 0, 0, F_MREQ | F_MRDY | F_HID),
              mk(0, 0, 0, F_HID),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, F_MREQ),
              mk(0, 0, 0, F_MREQ | F_MRDY),
              mk(0, 0, 0, F_HID),
              mk(0, 0, 0, F_HWB),
              mk(0, 0, 0, 8'h00)};
        e = '{E_0, E_DR, E_DR, E_DR, E_HALT, E_HALT, E_HALT,
              E_0, E_DR, E_MW, E_DR, E_DR, E_0, E_0};
        foreach (s[i]) begin
            if (i == 7) do_reset();
            if (i == 12) begin
                #1;
                RST = 1'b1;
                #1;
                total++;
                if (obs() !== E_0) begin
                    bad++;
                    $display("FAIL drain_mid_reset got=%b want=%b", obs(), E_0);
                end
                @(posedge CLK);
                RST = 1'b0;
                apply(mk(0, 0, 0, 8'h00));
            end
            drive_cycle(s[i], e[i]);
            #1;
            want = exp_q.pop_front();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL drain_halt[%0d] got=%b want=%b", i, obs(), want);
            end
        end
    endtask

    task automatic test_timeout();
        stim_t s [0:7];
        logic [10:0] e [0:7];
        logic [10:0] want;
        s = '{mk(0, 0, 0, F_MREQ),
              mk(0, 0, 0, F_MREQ),
              mk(0, 0, 0, F_MREQ),
              mk(0, 0, 0, F_MREQ),
              mk(0, 0, 0, F_MREQ),
              mk(0, 0, 0, F_MREQ | F_MRDY),
              mk(0, 0, 0, 8'h00),
              mk(0, 0, 0, 8'h00)};
        e = '{E_MW, E_MW, E_MW, E_MW, E_TMO, E_TMO, E_TMO, E_0};
        do_reset();
        foreach (s[i]) begin
            if (i == 7) do_reset();
            drive_cycle(s[i], e[i]);
            #1;
            want = exp_q.pop_front();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL timeout[%0d] got=%b want=%b", i, obs(), want);
            end
        end
    endtask

`ifdef PIPE_PERF_CNT_EN
    task automatic test_perf();
        stim_t s [0:4];
        logic [10:0] e [0:4];
        logic [10:0] want;
        s = '{mk(5, 0, 5, F_LD | F_U1),
              mk(0, 0, 0, 8'h00),
              mk(0, 8, 8, F_LD | F_U2),
              mk(0, 0, 0, F_RED),
              mk(0, 0, 0, 8'h00)};
        e = '{E_LU, E_0, E_LU, E_RD, E_0};
        do_reset();
        foreach (s[i]) begin
            drive_cycle(s[i], e[i]);
            #1;
            want = exp_q.pop_front();
            total++;
            if (obs() !== want) begin
                bad++;
                $display("FAIL perf_seq[%0d] got=%b want=%b", i, obs(), want);
            end
        end
        @(negedge CLK);
        #1;
        total++;
        if (bus.stall_cycles !== 32'd2) begin
            bad++;
            $display("FAIL perf_stall_cycles got=%0d want=2", bus.stall_cycles);
        end
        total++;
        if (bus.flush_count !== 32'd1) begin
            bad++;
            $display("FAIL perf_flush_count got=%0d want=1", bus.flush_count);
        end
    endtask
`endif

    initial begin
        total = 0;
        bad   = 0;
        RST   = 1'b1;
        apply(mk(0, 0, 0, 8'h00));
        test_reset();
        test_load_use();
        test_mem_wait();
        test_redirect();
        test_drain_halt();
        test_timeout();
`ifdef PIPE_PERF_CNT_EN
        test_perf();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. Drives the active-low-update WEN inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, plus PC hold and bubble-insert (kill) strobes. Handles load-use hazards, data-memory wait states with timeout, branch/jump redirect flushes, and halt drain. Sits at the top of the CPU beside the pipeline registers; state updates on the falling edge of CLK, the same edge as the pipeline registers.

Parameters:
REG_ADDR_W, 5, register index width
MEM_TIMEOUT, 255, max consecutive wait cycles before error; must be >= 1
CNT_W, 32, performance counter width (optional feature)

Ports:
CLK  in  1  clock; state updates on falling edge
RST  in  1  asynchronous reset, active-high
rs1_id  in  REG_ADDR_W  ID-stage source 1 index
rs2_id  in  REG_ADDR_W  ID-stage source 2 index
use_rs1_id  in  1  ID instruction reads rs1
use_rs2_id  in  1  ID instruction reads rs2
rd_ex  in  REG_ADDR_W  EX-stage destination
load_ex  in  1  EX instruction is a load (MemToReg & RWrEn)
mem_req  in  1  MEM stage accessing data memory
mem_ready  in  1  data memory completes access this cycle
redirect_mem  in  1  JMP_mem | (BR_mem & BranchCondTrue_mem)
halt_id  in  1  halt decoded in ID
halt_wb  in  1  halt reached WB
pc_hold  out  1  PC does not update
wen_if_id, wen_id_ex, wen_ex_mem, wen_mem_wb  out  1 each  1 = hold register (wired to WEN)
kill_if_id, kill_id_ex, kill_ex_mem, kill_mem_wb  out  1 each  register loads a NOP bubble (all control fields 0)
halted  out  1  pipeline stopped
mem_err  out  1  sticky memory timeout flag
stall_cycles  out  CNT_W  perf counter (optional)
flush_count  out  CNT_W  perf counter (optional)

Behaviour:
- Reset (RST=1, async): state RUN, timeout counter 0, mem_err 0, halted 0, counters 0. All hold/kill outputs 0 while RST is asserted.
- States: RUN, MEM_WAIT, DRAIN, HALTED. Outputs are combinational from state and current inputs.
- Event priority in RUN/DRAIN: mem wait > redirect > load-use > halt.
- Mem wait: mem_req & !mem_ready → pc_hold, wen_if_id, wen_id_ex, wen_ex_mem = 1; kill_mem_wb = 1; go to MEM_WAIT.
  - In MEM_WAIT, the timeout counter increments each cycle. mem_ready returns to the prior state (RUN or DRAIN) and clears the counter. The counter reaching MEM_TIMEOUT sets mem_err and goes to HALTED.
  - A redirect or load-use event during MEM_WAIT is ignored until the wait ends; inputs are frozen by the holds.
- Redirect: redirect_mem → kill_if_id, kill_id_ex, kill_ex_mem = 1 for exactly one cycle; PC is not held (it loads the target). If in DRAIN, the halt was on the wrong path, so return to RUN.
- Load-use: load_ex & rd_ex != 0 & ((use_rs1_id & rs1_id == rd_ex) | (use_rs2_id & rs2_id == rd_ex)) → pc_hold, wen_if_id = 1; kill_id_ex = 1. The bubble clears the condition, giving a one-cycle stall. rd_ex == 0 never stalls.
- Halt: halt_id in RUN with no higher-priority event → DRAIN.
  - DRAIN: pc_hold = 1, kill_if_id = 1 every cycle; older stages flow.
  - halt_wb → HALTED.
- HALTED: all wen_* = 1, pc_hold = 1, halted = 1. Exit only via RST.
- RST mid-MEM_WAIT or mid-DRAIN: immediate return to RUN with all outputs 0.

Optional Feature:
- PIPE_PERF_CNT_EN defined: stall_cycles increments on every falling edge where pc_hold = 1 and state != HALTED; flush_count increments once per accepted redirect. Both saturate at all-ones and clear on RST.
- Not defined: both outputs tied to 0, no counter flops.

Decomposition:
- Package pipeline_ctrl_pkg: state enum (RUN, MEM_WAIT, DRAIN, HALTED), REG_ADDR_W default, zero-register constant.
- One sub-module, load_use_detect: purely combinational compare producing the load-use stall bit.

Test Plan:
- Load x5, then add reading x5 → exactly one cycle with pc_hold = wen_if_id = kill_id_ex = 1; no stall if rd = x0.
- mem_req with mem_ready low for 3 cycles → holds asserted 3 cycles, kill_mem_wb = 1 each cycle, resume on ready; mem_err = 0.
- MEM_TIMEOUT = 4, mem_ready never rises → mem_err = 1 and halted = 1 after 4 wait cycles; held until RST.
- Taken branch in MEM with a halt already in ID/EX → single-cycle kills on three registers, state returns to RUN, halted stays 0.
- halt_id, then halt_wb 3 cycles later → DRAIN with kill_if_id for 3 cycles, then halted = 1; assert RST mid-drain in a second run → outputs 0 immediately.
- PIPE_PERF_CNT_EN: two load-use stalls plus one redirect → stall_cycles = 2, flush_count = 1.
